// File: rtl/mio_arb_pkg.sv
// Shared types and constants for the two-master MIO bus arbiter.
//   arb_state_e  : sequencer states (idle, bus access, response)
//   master_id_e  : master identifiers, used for the round-robin history
//   LatCntW      : width of the access-cycle counter (read latency 0..3)
//   StarveCntW   : width of the master 1 starvation counter (limit 1..15)
package mio_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } arb_state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_e;

  localparam int unsigned LatCntW    = 2;
  localparam int unsigned StarveCntW = 4;

endpackage

// File: rtl/mio_bus_arbiter_if.sv
// Request/response bundle between one bus master and the arbiter.
//   req   : request, held high until ack
//   we    : 1 = write, 0 = read
//   addr  : byte address
//   wdata : write data
//   ack   : one-cycle completion pulse
//   rdata : read data, valid with ack, held until the next read completes
// Modports: master drives the request side, slave (the arbiter) drives ack/rdata.
interface mio_bus_arbiter_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ack,
    output rdata
  );

endinterface

// File: rtl/mio_arb_pick.sv
// Combinational winner selection for the two-master arbiter.
//   i_req        : request vector, bit0 = master 0, bit1 = master 1
//   i_last_gnt   : master granted most recently (round-robin history)
//   i_starve_cnt : arbitrations lost in a row by a requesting master 1
//   o_win        : one-hot winner, 0 when nobody requests
// FIXED_PRI = 0 selects round-robin; 1 selects master 0 priority, with master 1
// forced through once it has lost M1_STARVE_MAX arbitrations in a row.
module mio_arb_pick
  import mio_arb_pkg::*;
#(
  parameter int unsigned FIXED_PRI     = 0,
  parameter int unsigned M1_STARVE_MAX = 2
) (
  input  logic [1:0]            i_req,
  input  master_id_e            i_last_gnt,
  input  logic [StarveCntW-1:0] i_starve_cnt,
  output logic [1:0]            o_win
);

  logic w_m1_forced;

  assign w_m1_forced = (i_starve_cnt == StarveCntW'(M1_STARVE_MAX));

  always_comb begin
    o_win = 2'b00;
    unique case (i_req)
      2'b01: o_win = 2'b01;
      2'b10: o_win = 2'b10;
      2'b11: begin
        if (FIXED_PRI != 0) begin
          o_win = w_m1_forced ? 2'b10 : 2'b01;
        end else begin
          // Contention goes to whichever master did not win last time.
          o_win = (i_last_gnt == M1) ? 2'b01 : 2'b10;
        end
      end
      default: o_win = 2'b00;
    endcase
  end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Two-master arbiter/sequencer in front of the MIO bus decoder.
// Latches the winning master's request, drives the decoder bus for a fixed
// number of cycles, then returns read data and a one-cycle ack to that master.
//   i_clk, i_rst  : clock and synchronous active-high reset
//   io_m0, io_m1  : master request bundles (CPU and auxiliary master)
//   o_bus_mem_w   : decoder mem_w
//   o_bus_addr    : decoder addr_bus
//   o_bus_wdata   : decoder Cpu_data2bus
//   i_bus_rdata   : decoder Cpu_data4bus
//   o_gnt         : one-hot current owner, 0 when idle
//   o_busy        : high while a transaction is in ACCESS or RESP
// Timing from a request sampled in IDLE at T0: writes drive mem_w at T1 and ack
// at T2; reads ack at T2+RD_LAT. RESP always returns to IDLE, so transactions
// are separated by at least one idle cycle.
module mio_bus_arbiter
  import mio_arb_pkg::*;
#(
  parameter int unsigned RD_LAT        = 1,
  parameter int unsigned FIXED_PRI     = 0,
  parameter int unsigned M1_STARVE_MAX = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  mio_bus_arbiter_if.slave         io_m0,
  mio_bus_arbiter_if.slave         io_m1,
  output logic                     o_bus_mem_w,
  output logic [31:0]              o_bus_addr,
  output logic [31:0]              o_bus_wdata,
  input  logic [31:0]              i_bus_rdata,
  output logic [1:0]               o_gnt,
  output logic                     o_busy
);

  arb_state_e            r_state;
  master_id_e            r_last_gnt;
  logic [StarveCntW-1:0] r_starve_cnt;
  logic [LatCntW-1:0]    r_cnt;
  logic [1:0]            r_gnt;
  logic [1:0]            r_ack;
  logic                  r_we;
  logic                  r_bus_mem_w;
  logic [31:0]           r_bus_addr;
  logic [31:0]           r_bus_wdata;
  logic [31:0]           r_m0_rdata;
  logic [31:0]           r_m1_rdata;

  logic [1:0]            w_req;
  logic [1:0]            w_win;
  logic                  w_sel_we;
  logic [31:0]           w_sel_addr;
  logic [31:0]           w_sel_wdata;

  assign w_req = {io_m1.req, io_m0.req};

  mio_arb_pick #(
    .FIXED_PRI     (FIXED_PRI),
    .M1_STARVE_MAX (M1_STARVE_MAX)
  ) u_pick (
    .i_req        (w_req),
    .i_last_gnt   (r_last_gnt),
    .i_starve_cnt (r_starve_cnt),
    .o_win        (w_win)
  );

  // Request fields of the winner, latched at grant.
  assign w_sel_we    = w_win[1] ? io_m1.we    : io_m0.we;
  assign w_sel_addr  = w_win[1] ? io_m1.addr  : io_m0.addr;
  assign w_sel_wdata = w_win[1] ? io_m1.wdata : io_m0.wdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_last_gnt   <= M1;  // m0 wins the first tie after reset
      r_starve_cnt <= '0;
      r_cnt        <= '0;
      r_gnt        <= 2'b00;
      r_ack        <= 2'b00;
      r_we         <= 1'b0;
      r_bus_mem_w  <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if ((FIXED_PRI != 0) && !io_m1.req) begin
            r_starve_cnt <= '0;
          end
          if (w_win != 2'b00) begin
            r_state     <= StAccess;
            r_gnt       <= w_win;
            r_we        <= w_sel_we;
            r_bus_mem_w <= w_sel_we;
            r_bus_addr  <= w_sel_addr;
            r_bus_wdata <= w_sel_wdata;
            // Counter holds the ACCESS cycles remaining after the first one.
            r_cnt       <= w_sel_we ? '0 : LatCntW'(RD_LAT);
            if (w_win[1]) begin
              r_last_gnt   <= M1;
              r_starve_cnt <= '0;
            end else begin
              r_last_gnt <= M0;
              if ((FIXED_PRI != 0) && io_m1.req) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
              end
            end
          end
        end

        StAccess: begin
          if (r_cnt == '0) begin
            r_state     <= StResp;
            r_ack       <= r_gnt;
            r_bus_mem_w <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            if (!r_we) begin
              if (r_gnt[1]) begin
                r_m1_rdata <= i_bus_rdata;
              end else begin
                r_m0_rdata <= i_bus_rdata;
              end
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        StResp: begin
          r_state <= StIdle;
          r_ack   <= 2'b00;
          r_gnt   <= 2'b00;
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_m0.ack   = r_ack[0];
  assign io_m1.ack   = r_ack[1];
  assign io_m0.rdata = r_m0_rdata;
  assign io_m1.rdata = r_m1_rdata;
  assign o_bus_mem_w = r_bus_mem_w;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_gnt       = r_gnt;
  assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Bench for mio_bus_arbiter: instance A is round-robin with read latency 1,
// instance B is fixed priority (starve limit 2) with read latency 2. A
// transaction-timeline model predicts every output each cycle; directed
// sequences add explicit checks for the headline scenarios.
module tb_mio_bus_arbiter;

  localparam int unsigned LatA    = 1;
  localparam int unsigned LatB    = 2;
  localparam int          StarveB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_v = 2'b11;
  logic [1:0]  req_v   [2] = '{2'b00, 2'b00};
  logic [1:0]  we_v    [2] = '{2'b00, 2'b00};
  logic [31:0] addr_v  [2][2] = '{'{32'h0, 32'h0}, '{32'h0, 32'h0}};
  logic [31:0] wdata_v [2][2] = '{'{32'h0, 32'h0}, '{32'h0, 32'h0}};

  logic [1:0]  ack_o    [2];
  logic [31:0] rdata_o  [2][2];
  logic [1:0]  mem_w_o;
  logic [1:0]  busy_o;
  logic [31:0] baddr_o  [2];
  logic [31:0] bwdata_o [2];
  logic [31:0] brdata_i [2];
  logic [1:0]  gnt_o    [2];

  mio_bus_arbiter_if a_m0 ();
  mio_bus_arbiter_if a_m1 ();
  mio_bus_arbiter_if b_m0 ();
  mio_bus_arbiter_if b_m1 ();

  assign a_m0.req = req_v[0][0];  assign a_m0.we = we_v[0][0];
  assign a_m1.req = req_v[0][1];  assign a_m1.we = we_v[0][1];
  assign b_m0.req = req_v[1][0];  assign b_m0.we = we_v[1][0];
  assign b_m1.req = req_v[1][1];  assign b_m1.we = we_v[1][1];
  assign a_m0.addr = addr_v[0][0];  assign a_m0.wdata = wdata_v[0][0];
  assign a_m1.addr = addr_v[0][1];  assign a_m1.wdata = wdata_v[0][1];
  assign b_m0.addr = addr_v[1][0];  assign b_m0.wdata = wdata_v[1][0];
  assign b_m1.addr = addr_v[1][1];  assign b_m1.wdata = wdata_v[1][1];
  assign ack_o[0] = {a_m1.ack, a_m0.ack};
  assign ack_o[1] = {b_m1.ack, b_m0.ack};
  assign rdata_o[0][0] = a_m0.rdata;  assign rdata_o[0][1] = a_m1.rdata;
  assign rdata_o[1][0] = b_m0.rdata;  assign rdata_o[1][1] = b_m1.rdata;

  mio_bus_arbiter #(
    .RD_LAT        (LatA),
    .FIXED_PRI     (0),
    .M1_STARVE_MAX (2)
  ) u_dut_a (
    .i_clk       (clk),
    .i_rst       (rst_v[0]),
    .io_m0       (a_m0),
    .io_m1       (a_m1),
    .o_bus_mem_w (mem_w_o[0]),
    .o_bus_addr  (baddr_o[0]),
    .o_bus_wdata (bwdata_o[0]),
    .i_bus_rdata (brdata_i[0]),
    .o_gnt       (gnt_o[0]),
    .o_busy      (busy_o[0])
  );

  mio_bus_arbiter #(
    .RD_LAT        (LatB),
    .FIXED_PRI     (1),
    .M1_STARVE_MAX (StarveB)
  ) u_dut_b (
    .i_clk       (clk),
    .i_rst       (rst_v[1]),
    .io_m0       (b_m0),
    .io_m1       (b_m1),
    .o_bus_mem_w (mem_w_o[1]),
    .o_bus_addr  (baddr_o[1]),
    .o_bus_wdata (bwdata_o[1]),
    .i_bus_rdata (brdata_i[1]),
    .o_gnt       (gnt_o[1]),
    .o_busy      (busy_o[1])
  );

  // Peripheral model: read data is a function of the address, delivered
  // RD_LAT cycles after the address appears on the bus.
  function automatic logic [31:0] rd_hash(input logic [31:0] a);
    return a ^ 32'hF000_0A5C;
  endfunction

  logic [31:0] pipe [2][4];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      pipe[d][0] <= rd_hash(baddr_o[d]);
      for (int i = 1; i < 4; i++) pipe[d][i] <= pipe[d][i-1];
    end
  end
  assign brdata_i[0] = pipe[0][LatA-1];
  assign brdata_i[1] = pipe[1][LatB-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Transaction-timeline model: m_k = 0 is an idle cycle, otherwise the
  // k-th of m_len cycles of the current transaction (the last one is the ack).
  int          m_k      [2] = '{0, 0};
  int          m_len    [2] = '{2, 2};
  int          m_own    [2] = '{0, 0};
  int          m_last   [2] = '{1, 1};
  int          m_starve [2] = '{0, 0};
  logic        m_we     [2] = '{1'b0, 1'b0};
  logic [31:0] m_addr   [2] = '{32'h0, 32'h0};
  logic [31:0] m_wdata  [2] = '{32'h0, 32'h0};
  logic [31:0] m_rd     [2][2] = '{'{32'h0, 32'h0}, '{32'h0, 32'h0}};
  logic [1:0]  obs_a [$];
  logic [1:0]  obs_b [$];

  function automatic bit is_fixed(input int d);
    return d == 1;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? int'(LatA) : int'(LatB);
  endfunction

  task automatic model_step(input int d);
    int win;
    if (rst_v[d]) begin
      m_k[d] = 0; m_last[d] = 1; m_starve[d] = 0;
      m_rd[d][0] = '0; m_rd[d][1] = '0;
      return;
    end
    if (m_k[d] == 0) begin
      if (is_fixed(d) && !req_v[d][1]) m_starve[d] = 0;
      win = -1;
      if (req_v[d] == 2'b11) begin
        if (is_fixed(d)) win = (m_starve[d] == StarveB) ? 1 : 0;
        else             win = 1 - m_last[d];
      end else if (req_v[d][0]) win = 0;
      else if (req_v[d][1])     win = 1;
      if (win >= 0) begin
        if (win == 1) m_starve[d] = 0;
        else if (is_fixed(d) && req_v[d][1]) m_starve[d]++;
        m_last[d]  = win;
        m_own[d]   = win;
        m_we[d]    = we_v[d][win];
        m_addr[d]  = addr_v[d][win];
        m_wdata[d] = wdata_v[d][win];
        m_len[d]   = m_we[d] ? 2 : lat_of(d) + 2;
        m_k[d]     = 1;
      end
    end else if (m_k[d] < m_len[d]) begin
      m_k[d]++;
      if (m_k[d] == m_len[d] && !m_we[d]) m_rd[d][m_own[d]] = rd_hash(m_addr[d]);
    end else begin
      m_k[d] = 0;
    end
  endtask

  task automatic check_outputs(input int d);
    string      p;
    logic       on;
    logic       drv;
    logic [1:0] eg;
    p   = (d == 0) ? "a" : "b";
    on  = (m_k[d] != 0);
    drv = on && (m_k[d] < m_len[d]);
    eg  = on ? ((m_own[d] == 1) ? 2'b10 : 2'b01) : 2'b00;
    chk_eq($sformatf("%s_gnt", p), 32'(gnt_o[d]), 32'(eg));
    chk_eq($sformatf("%s_busy", p), 32'(busy_o[d]), 32'(on));
    chk_eq($sformatf("%s_mem_w", p), 32'(mem_w_o[d]), 32'(drv && m_we[d]));
    chk_eq($sformatf("%s_bus_addr", p), baddr_o[d], drv ? m_addr[d] : 32'h0);
    chk_eq($sformatf("%s_bus_wdata", p), bwdata_o[d], drv ? m_wdata[d] : 32'h0);
    chk_eq($sformatf("%s_ack", p), 32'(ack_o[d]), (on && m_k[d] == m_len[d]) ? 32'(eg) : 32'h0);
    chk_eq($sformatf("%s_m0_rdata", p), rdata_o[d][0], m_rd[d][0]);
    chk_eq($sformatf("%s_m1_rdata", p), rdata_o[d][1], m_rd[d][1]);
    if (m_k[d] == 1) begin
      if (d == 0) obs_a.push_back(gnt_o[d]);
      else        obs_b.push_back(gnt_o[d]);
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    #1;
    check_outputs(0);
    check_outputs(1);
  end

  task automatic new_req(input int d, input int m);
    req_v[d][m]   = 1'b1;
    we_v[d][m]    = 1'($urandom_range(0, 1));
    addr_v[d][m]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
    wdata_v[d][m] = $urandom;
  endtask

  // Masters hold req until their ack, then re-request or drop; an owner may
  // scribble over its request fields mid-transaction, which must be ignored.
  task automatic rand_master(input int d, input int m);
    bool_t_unused: begin end
    if (m_k[d] != 0 && m_own[d] == m && m_k[d] == m_len[d]) begin
      if ($urandom_range(0, 1) == 1) new_req(d, m);
      else req_v[d][m] = 1'b0;
    end else if (!req_v[d][m]) begin
      if ($urandom_range(0, 2) == 0) new_req(d, m);
    end else if (m_k[d] != 0 && m_own[d] == m && m_k[d] < m_len[d]) begin
      if ($urandom_range(0, 3) == 0) begin
        addr_v[d][m]  = $urandom;
        wdata_v[d][m] = $urandom;
        we_v[d][m]    = 1'($urandom_range(0, 1));
      end
    end
  endtask

  logic [1:0] exp_rr [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [1:0] exp_fp [6] = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};

  initial begin
    logic [1:0] g;
    repeat (3) @(negedge clk);
    rst_v = 2'b00;
    @(negedge clk);

    // m0 write on A
    req_v[0][0] = 1'b1; we_v[0][0] = 1'b1;
    addr_v[0][0] = 32'h0000_0010; wdata_v[0][0] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk_eq("wr_t1_mem_w", 32'(mem_w_o[0]), 32'h1);
    chk_eq("wr_t1_addr", baddr_o[0], 32'h0000_0010);
    chk_eq("wr_t1_wdata", bwdata_o[0], 32'hDEAD_BEEF);
    chk_eq("wr_t1_gnt", 32'(gnt_o[0]), 32'h1);
    @(negedge clk);
    chk_eq("wr_t2_ack", 32'(ack_o[0]), 32'h1);
    req_v[0][0] = 1'b0;
    @(negedge clk);
    chk_eq("wr_t3_busy", 32'(busy_o[0]), 32'h0);

    // m1 read on A
    @(negedge clk);
    req_v[0][1] = 1'b1; we_v[0][1] = 1'b0; addr_v[0][1] = 32'hF000_0000;
    @(negedge clk);
    chk_eq("rd_t1_mem_w", 32'(mem_w_o[0]), 32'h0);
    chk_eq("rd_t1_gnt", 32'(gnt_o[0]), 32'h2);
    @(negedge clk);
    chk_eq("rd_t2_mem_w", 32'(mem_w_o[0]), 32'h0);
    chk_eq("rd_t2_ack", 32'(ack_o[0]), 32'h0);
    @(negedge clk);
    chk_eq("rd_t3_ack", 32'(ack_o[0]), 32'h2);
    chk_eq("rd_t3_rdata", rdata_o[0][1], 32'h0000_0A5C);
    req_v[0][1] = 1'b0;

    // Address changed by the owner after grant must not reach the bus
    @(negedge clk);
    req_v[0][0] = 1'b1; we_v[0][0] = 1'b0; addr_v[0][0] = 32'h0000_0020;
    @(negedge clk);
    chk_eq("hold_t1_addr", baddr_o[0], 32'h0000_0020);
    addr_v[0][0] = 32'hE000_0000;
    @(negedge clk);
    chk_eq("hold_t2_addr", baddr_o[0], 32'h0000_0020);
    @(negedge clk);
    chk_eq("hold_t3_rdata", rdata_o[0][0], rd_hash(32'h0000_0020));
    req_v[0][0] = 1'b0;

    // Reset during the second ACCESS cycle of a read, then the retry
    @(negedge clk);
    req_v[0][0] = 1'b1; we_v[0][0] = 1'b0; addr_v[0][0] = 32'h0000_1234;
    @(negedge clk);
    @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    chk_eq("rst_ack", 32'(ack_o[0]), 32'h0);
    chk_eq("rst_busy", 32'(busy_o[0]), 32'h0);
    chk_eq("rst_gnt", 32'(gnt_o[0]), 32'h0);
    chk_eq("rst_addr", baddr_o[0], 32'h0);
    chk_eq("rst_rdata", rdata_o[0][0], 32'h0);
    rst_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("retry_ack", 32'(ack_o[0]), 32'h1);
    chk_eq("retry_rdata", rdata_o[0][0], rd_hash(32'h0000_1234));
    req_v[0][0] = 1'b0;

    // Both masters writing continuously from reset, on both instances
    @(negedge clk);
    rst_v = 2'b11;
    obs_a.delete();
    obs_b.delete();
    @(negedge clk);
    rst_v = 2'b00;
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 2; m++) begin
        req_v[d][m] = 1'b1; we_v[d][m] = 1'b1;
        addr_v[d][m] = 32'h100 + 32'(16 * m); wdata_v[d][m] = 32'hC0DE_0000 + 32'(m);
      end
    end
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      g = (i < obs_a.size()) ? obs_a[i] : 2'b11;
      chk_eq($sformatf("rr_order%0d", i), 32'(g), 32'(exp_rr[i]));
    end
    for (int i = 0; i < 6; i++) begin
      g = (i < obs_b.size()) ? obs_b[i] : 2'b11;
      chk_eq($sformatf("fp_order%0d", i), 32'(g), 32'(exp_fp[i]));
    end
    req_v[0] = 2'b00;
    req_v[1] = 2'b00;
    repeat (4) @(negedge clk);

    // Randomised traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        rst_v[d] = ($urandom_range(0, 199) == 0);
        for (int m = 0; m < 2; m++) rand_master(d, m);
      end
    end
    @(negedge clk);
    rst_v = 2'b00;
    req_v[0] = 2'b00;
    req_v[1] = 2'b00;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mio_bus_arbiter.md
Name: mio_bus_arbiter

Overview:
- Two-master arbiter/sequencer in front of the MIO bus decoder.
- Shares the single peripheral/data-RAM bus between the CPU (master 0) and an auxiliary master (master 1, e.g. display/board-refresh engine).
- Latches the winning master's request and drives the decoder's mem_w/addr/data inputs for a fixed number of cycles. Returns read data plus a one-cycle ack to that master.
- Sits between both masters and the MIO bus decoder's Cpu_data2bus/addr_bus/mem_w/Cpu_data4bus pins.

Parameters:
- RD_LAT, 1, cycles from address driven to bus_rdata valid (legal 0..3).
- FIXED_PRI, 0, 0 = round-robin; 1 = master 0 priority with starvation guard.
- M1_STARVE_MAX, 2, when FIXED_PRI=1: consecutive arbitrations lost by a requesting m1 before m1 is forced to win (legal 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- m0_req  in  1  master 0 request; held high until m0_ack
- m0_we  in  1  master 0 write (1) / read (0)
- m0_addr  in  32  master 0 byte address
- m0_wdata  in  32  master 0 write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  32  read data, valid when m0_ack=1
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0 for master 1
- bus_mem_w  out  1  to decoder mem_w
- bus_addr  out  32  to decoder addr_bus
- bus_wdata  out  32  to decoder Cpu_data2bus
- bus_rdata  in  32  from decoder Cpu_data4bus
- gnt  out  2  one-hot current owner (bit0=m0, bit1=m1); 0 when idle
- busy  out  1  high in ACCESS and RESP

Behaviour:
- One clock; reset is synchronous and active-high.
- States: IDLE, ACCESS, RESP.
- Reset (any state, including mid-transaction):
  - state=IDLE; all outputs 0; no ack emitted for the aborted transaction.
  - last_gnt=m1, so m0 wins the first tie; starve counter=0.
- IDLE:
  - bus_mem_w=0, bus_addr=0, bus_wdata=0, gnt=0.
  - If any req is high: pick a winner, latch its we/addr/wdata, set gnt, load cycle counter, go to ACCESS.
- Winner, FIXED_PRI=0 (round-robin):
  - Only one requester: it wins.
  - Both request: the master not equal to last_gnt wins. last_gnt updates at grant.
- Winner, FIXED_PRI=1:
  - m0 wins whenever it requests, unless starve_cnt==M1_STARVE_MAX, in which case m1 wins.
  - starve_cnt increments on each grant to m0 while m1_req=1.
  - starve_cnt clears on any grant to m1 and whenever m1_req=0 in IDLE.
- ACCESS:
  - Drives the latched addr/wdata; master-side changes after grant are ignored.
  - Write: 1 cycle with bus_mem_w=1, then RESP.
  - Read: RD_LAT+1 cycles with bus_mem_w=0. bus_rdata is registered into the owner's rdata on the last ACCESS cycle, then RESP.
- RESP:
  - One cycle; owner's ack=1. Owner's rdata holds captured data (reads) or last value (writes). bus outputs back to 0; bus_mem_w=0.
  - Next state is always IDLE, giving one guaranteed idle cycle between transactions.
  - A master must sample ack and drop or re-assert req for the next transaction by the IDLE cycle.
- Latency from req sampled in IDLE (cycle T0):
  - Write: bus_mem_w at T1, ack at T2.
  - Read: ack at T2+RD_LAT.
- m*_rdata retains its value until the next read completes for that master; reset value 0.
- Never more than one gnt bit set; ack only to the granted master.
- Simultaneous req rise and reset: reset wins.

Decomposition:
- Package mio_arb_pkg: state encoding (IDLE/ACCESS/RESP), master IDs M0/M1, counter width constants.
- One sub-module: mio_arb_pick, a combinational winner selector.
  - Inputs: req[1:0], last_gnt, starve_cnt, FIXED_PRI, M1_STARVE_MAX.
  - Output: one-hot winner.

Test Plan:
- m0 write addr 0x00000010, data 0xDEADBEEF, at T0 -> T1: bus_mem_w=1, bus_addr=0x10, bus_wdata=0xDEADBEEF, gnt=01; T2: m0_ack=1; T3: busy=0.
- m1 read addr 0xF0000000, RD_LAT=1, bus_rdata=0x00000A5C -> bus_mem_w=0 on T1..T2; T3: m1_ack=1, m1_rdata=0x00000A5C.
- FIXED_PRI=0, both masters request continuously from reset -> grant order m0, m1, m0, m1; each ack 3 cycles (write) apart from the previous; never two gnt bits set.
- FIXED_PRI=1, M1_STARVE_MAX=2, both requesting continuously -> grant order m0, m0, m1, m0, m0, m1.
- rst pulsed during a read's second ACCESS cycle -> next cycle all outputs 0, no m*_ack; a subsequent m0 read completes normally with correct data.
- m0_addr changed from 0x00000020 to 0xE0000000 one cycle after grant -> bus_addr stays 0x00000020 for the whole transaction.
